// File: rtl/link_rr_arbiter.sv
// Packet-granular round-robin arbiter for one credit-flow-controlled router link, with a source-stall
// watchdog that closes a hung packet with a synthetic EOP and quarantines the offending port.
`timescale 1ns/1ps
module link_rr_arbiter #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned FLIT_SIZE = 32,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [15:0] ADDRESS   = 16'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_PORTS-1:0]             tx_i,
    input  logic [N_PORTS*FLIT_SIZE-1:0]   data_i,
    input  logic [N_PORTS-1:0]             eop_i,
    output logic [N_PORTS-1:0]             cr_tx_o,
    output logic                           rx_o,
    output logic [FLIT_SIZE-1:0]           data_o,
    output logic                           eop_o,
    input  logic                           cr_rx_i,
    input  logic [N_PORTS-1:0]             clear_i,
    output logic [N_PORTS-1:0]             quarantine_o,
    output logic                           timeout_o,
    output logic [$clog2(N_PORTS)-1:0]     timeout_port_o
);

    localparam int unsigned IDX_W = $clog2(N_PORTS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_PORTS-1:0]   quar_q, quar_d, quar_set;
    logic                 timeout_q, timeout_d;
    logic [IDX_W-1:0]     tport_q, tport_d;

    logic [FLIT_SIZE-1:0] flits [N_PORTS];
    logic [N_PORTS-1:0]   elig;
    logic                 arb_found;
    logic [IDX_W-1:0]     arb_sel;
    logic [IDX_W-1:0]     arb_idx;

    always_comb begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            flits[p] = data_i[p*FLIT_SIZE +: FLIT_SIZE];
        end
    end

    // Search starts one past the last grant, so the previous winner ends up with lowest priority.
    always_comb begin
        elig      = tx_i & ~quar_q;
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            arb_idx = IDX_W'((32'(ptr_q) + i) % N_PORTS);
            if (!arb_found && elig[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        quar_set  = '0;
        timeout_d = 1'b0;
        tport_d   = tport_q;
        cr_tx_o   = '0;
        rx_o      = 1'b0;
        data_o    = '0;
        eop_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d = StGrant;
                    grant_d = arb_sel;
                    ptr_d   = arb_sel;
                end
            end
            StGrant: begin
                rx_o              = tx_i[grant_q];
                data_o            = flits[grant_q];
                eop_o             = eop_i[grant_q];
                cr_tx_o[grant_q]  = cr_rx_i & ~quar_q[grant_q];
                if (tx_i[grant_q] && cr_rx_i) begin
                    cnt_d = '0;
                    if (eop_i[grant_q]) begin
                        state_d = StIdle;
                    end
                end else if (!tx_i[grant_q]) begin
                    // Router backpressure (tx=1, cr=0) falls through and holds the count.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d           = StAbort;
                        cnt_d             = '0;
                        timeout_d         = 1'b1;
                        tport_d           = grant_q;
                        quar_set[grant_q] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StAbort: begin
                rx_o  = 1'b1;
                eop_o = 1'b1;
                if (cr_rx_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        quar_d = (quar_q & ~clear_i) | quar_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            ptr_q     <= IDX_W'(N_PORTS - 1);
            cnt_q     <= '0;
            quar_q    <= '0;
            timeout_q <= 1'b0;
            tport_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            quar_q    <= quar_d;
            timeout_q <= timeout_d;
            tport_q   <= tport_d;
        end
    end

    assign quarantine_o   = quar_q;
    assign timeout_o      = timeout_q;
    assign timeout_port_o = tport_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && state_q == StGrant && state_d == StAbort) begin
            $display("[%0.6f ms] router %02hx x %02hx: port %0d stalled, packet aborted",
                     $realtime / 1.0e6, ADDRESS[15:8], ADDRESS[7:0], grant_q);
        end
    end
`endif

endmodule

// File: tb/tb_link_rr_arbiter.sv
// Directed bench for link_rr_arbiter: arbitration order, passthrough, watchdog abort, quarantine
// set/clear priority, backpressure immunity and asynchronous reset.
`timescale 1ns/1ps
module tb_link_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned TO = 4;

    logic           clk_i   = 1'b0;
    logic           rst_ni  = 1'b0;
    logic [N-1:0]   tx_i    = '0;
    logic [N*W-1:0] data_i  = '0;
    logic [N-1:0]   eop_i   = '0;
    logic [N-1:0]   clear_i = '0;
    logic           cr_rx_i = 1'b0;
    logic [N-1:0]   cr_tx_o;
    logic           rx_o;
    logic [W-1:0]   data_o;
    logic           eop_o;
    logic [N-1:0]   quarantine_o;
    logic           timeout_o;
    logic [1:0]     timeout_port_o;

    int checks = 0;
    int errors = 0;

    link_rr_arbiter #(
        .N_PORTS   (N),
        .FLIT_SIZE (W),
        .TIMEOUT   (TO),
        .ADDRESS   (16'h0102)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tx_i           (tx_i),
        .data_i         (data_i),
        .eop_i          (eop_i),
        .cr_tx_o        (cr_tx_o),
        .rx_o           (rx_o),
        .data_o         (data_o),
        .eop_o          (eop_o),
        .cr_rx_i        (cr_rx_i),
        .clear_i        (clear_i),
        .quarantine_o   (quarantine_o),
        .timeout_o      (timeout_o),
        .timeout_port_o (timeout_port_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_flit(input int p, input logic [W-1:0] d, input logic e);
        data_i[p*W +: W] = d;
        eop_i[p]         = e;
    endtask

    task automatic expect_out(input string tag, input logic rx, input logic [W-1:0] d,
                              input logic e, input logic [N-1:0] cr);
        check({tag, ".rx"},   rx_o,    rx);
        check({tag, ".data"}, data_o,  d);
        check({tag, ".eop"},  eop_o,   e);
        check({tag, ".cr"},   cr_tx_o, cr);
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 1'b0, '0, 1'b0, '0);
    endtask

    // Drives an n-flit packet on a port that is granted in the current cycle.
    task automatic send_pkt(input string tag, input int p, input int n, input logic [W-1:0] base);
        logic [N-1:0] oh;
        oh = 4'b0001 << p;
        for (int k = 0; k < n; k++) begin
            set_flit(p, base + W'(k), k == n - 1);
            settle();
            expect_out($sformatf("%s.f%0d", tag, k), 1'b1, base + W'(k), k == n - 1, oh);
            cyc();
        end
        tx_i[p]  = 1'b0;
        eop_i[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int order [8];
        logic [N-1:0] oh;
        order = '{3, 0, 1, 2, 3, 0, 1, 2};

        // Reset values
        #2;
        expect_idle("rst");
        check("rst.quar", quarantine_o, 4'b0000);
        check("rst.to", timeout_o, 1'b0);
        check("rst.tport", timeout_port_o, 2'd0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        cr_rx_i = 1'b1;

        // T1: ports 0 and 2 with 3-flit packets
        cyc();
        tx_i = 4'b0101;
        set_flit(0, 32'hA000_0000, 1'b0);
        set_flit(2, 32'hC000_0000, 1'b0);
        settle();
        expect_idle("t1.c0");
        cyc();
        send_pkt("t1.p0", 0, 3, 32'hA000_0000);
        settle();
        expect_idle("t1.c4");
        cyc();
        send_pkt("t1.p2", 2, 3, 32'hC000_0000);

        // T2: all ports, single-flit packets; pointer is 2 here
        tx_i  = 4'b1111;
        eop_i = 4'b1111;
        for (int p = 0; p < 4; p++) data_i[p*W +: W] = 32'hD0D0_0000 | W'(p);
        for (int i = 0; i < 8; i++) begin
            settle();
            expect_idle($sformatf("t2.idle%0d", i));
            cyc();
            oh = 4'b0001 << order[i];
            settle();
            expect_out($sformatf("t2.g%0d", i), 1'b1, 32'hD0D0_0000 | W'(order[i]), 1'b1, oh);
            cyc();
        end
        tx_i  = '0;
        eop_i = '0;

        // T3: port 1 stalls after one flit
        tx_i = 4'b0010;
        set_flit(1, 32'hB1B1_0001, 1'b0);
        settle();
        expect_idle("t3.idle");
        cyc();
        settle();
        expect_out("t3.f0", 1'b1, 32'hB1B1_0001, 1'b0, 4'b0010);
        cyc();
        tx_i[1] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            settle();
            expect_out($sformatf("t3.stall%0d", s), 1'b0, 32'hB1B1_0001, 1'b0, 4'b0010);
            check($sformatf("t3.to_low%0d", s), timeout_o, 1'b0);
            cyc();
        end
        cr_rx_i = 1'b0;
        settle();
        expect_out("t3.abort", 1'b1, '0, 1'b1, 4'b0000);
        check("t3.to", timeout_o, 1'b1);
        check("t3.tport", timeout_port_o, 2'd1);
        check("t3.quar", quarantine_o, 4'b0010);
        cyc();
        settle();
        expect_out("t3.abort_hold", 1'b1, '0, 1'b1, 4'b0000);
        check("t3.to_pulse", timeout_o, 1'b0);
        cr_rx_i = 1'b1;
        cyc();
        tx_i = 4'b0011;
        set_flit(0, 32'hA5A5_0000, 1'b1);
        set_flit(1, 32'hB1B1_0002, 1'b1);
        settle();
        expect_idle("t3.after");
        check("t3.quar_hold", quarantine_o, 4'b0010);
        cyc();
        settle();
        expect_out("t3.p0", 1'b1, 32'hA5A5_0000, 1'b1, 4'b0001);
        cyc();
        tx_i = 4'b0010;
        for (int s = 0; s < 3; s++) begin
            settle();
            expect_idle($sformatf("t3.ignored%0d", s));
            cyc();
        end
        tx_i = '0;

        // T4: port 3 under long router backpressure must not abort
        tx_i = 4'b1000;
        set_flit(3, 32'h3333_0000, 1'b0);
        cr_rx_i = 1'b0;
        settle();
        expect_idle("t4.idle");
        cyc();
        for (int s = 0; s < 50; s++) begin
            settle();
            check($sformatf("t4.bp_rx%0d", s), rx_o, 1'b1);
            check($sformatf("t4.bp_to%0d", s), timeout_o, 1'b0);
            cyc();
        end
        cr_rx_i = 1'b1;
        send_pkt("t4.p3", 3, 2, 32'hE333_0000);
        settle();
        expect_idle("t4.done");
        check("t4.quar", quarantine_o, 4'b0010);

        // T5: set wins over a same-edge clear; later clear re-enables port 1
        clear_i = 4'b0010;
        cyc();
        clear_i = '0;
        settle();
        check("t5.cleared", quarantine_o, 4'b0000);
        tx_i = 4'b0010;
        set_flit(1, 32'hB2B2_0000, 1'b0);
        cyc();
        tx_i[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            settle();
            check($sformatf("t5.stall%0d", s), rx_o, 1'b0);
            cyc();
        end
        tx_i[1] = 1'b1;
        cr_rx_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            expect_out($sformatf("t5.bp%0d", s), 1'b1, 32'hB2B2_0000, 1'b0, 4'b0000);
            cyc();
        end
        cr_rx_i = 1'b1;
        tx_i[1] = 1'b0;
        settle();
        check("t5.not_yet", rx_o, 1'b0);
        cyc();
        clear_i = 4'b0010;
        settle();
        check("t5.last_stall", rx_o, 1'b0);
        cyc();
        clear_i = '0;
        settle();
        expect_out("t5.abort", 1'b1, '0, 1'b1, 4'b0000);
        check("t5.to", timeout_o, 1'b1);
        check("t5.tport", timeout_port_o, 2'd1);
        check("t5.set_wins", quarantine_o, 4'b0010);
        cyc();
        clear_i = 4'b0010;
        settle();
        check("t5.quar_before_clear", quarantine_o, 4'b0010);
        cyc();
        clear_i = '0;
        settle();
        check("t5.quar_cleared", quarantine_o, 4'b0000);
        check("t5.tport_hold", timeout_port_o, 2'd1);
        tx_i = 4'b0010;
        set_flit(1, 32'hB2B2_0005, 1'b1);
        settle();
        expect_idle("t5.idle");
        cyc();
        send_pkt("t5.regrant", 1, 1, 32'hB2B2_0005);

        // T6: reset during 2nd flit of port 2's packet; port 0 first after release
        tx_i = 4'b0101;
        set_flit(0, 32'h6000_0000, 1'b0);
        set_flit(2, 32'h6200_0000, 1'b0);
        settle();
        expect_idle("t6.idle");
        cyc();
        settle();
        expect_out("t6.f0", 1'b1, 32'h6200_0000, 1'b0, 4'b0100);
        cyc();
        set_flit(2, 32'h6200_0001, 1'b0);
        settle();
        expect_out("t6.f1", 1'b1, 32'h6200_0001, 1'b0, 4'b0100);
        rst_ni = 1'b0;
        #1;
        expect_idle("t6.rst");
        check("t6.tport", timeout_port_o, 2'd0);
        check("t6.quar", quarantine_o, 4'b0000);
        check("t6.to", timeout_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        send_pkt("t6.p0first", 0, 2, 32'h6000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
